// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between message producers, the round-robin arbiter and the
// UART serializer. The arbiter takes the slave modport; producers/serializer the master.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_ready;
  logic                 grant_valid;
  logic [GW-1:0]        grant_id;
  logic                 msg_done;
  logic                 timeout_err;

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, grant_valid, grant_id, msg_done, timeout_err
  );

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, grant_valid, grant_id, msg_done, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter feeding one byte-wide UART serializer
// through a single holding register, with producer-stall timeout and inter-message gap.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic              mclk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int PW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [PW-1:0] GAP_LAST = PW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GW-1:0] LAST_ID  = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, LOCK, GAP} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [GW-1:0] gid_q, gid_d;
  logic          gvalid_q, gvalid_d;
  logic          txv_q, txv_d;
  logic [7:0]    txd_q, txd_d;
  logic          hlast_q, hlast_d;
  logic          done_q, done_d;
  logic          tmo_q, tmo_d;
  logic [PW-1:0] gap_cnt_q, gap_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  logic [GW-1:0]      win_id, lo_id, hi_id;
  logic               hi_found;
  logic               sel_valid, sel_last;
  logic [7:0]         sel_data;
  logic [NUM_REQ-1:0] ready;
  logic               capture, drain;
  logic [GW-1:0]      ptr_next;

  // Lowest set bit at or above the pointer wins; otherwise wrap to the lowest set bit.
  always_comb begin
    lo_id    = '0;
    hi_id    = '0;
    hi_found = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (bus.req_valid[j]) begin
        lo_id = GW'(j);
        if (GW'(j) >= ptr_q) begin
          hi_id    = GW'(j);
          hi_found = 1'b1;
        end
      end
    end
    win_id = hi_found ? hi_id : lo_id;
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    ready     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gid_q == GW'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_data[i*8 +: 8];
        ready[i]  = (state_q == LOCK) && !txv_q;
      end
    end
  end

  assign capture  = (state_q == LOCK) && !txv_q && sel_valid;
  assign drain    = txv_q && bus.tx_ready;
  assign ptr_next = (gid_q == LAST_ID) ? '0 : gid_q + GW'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    gvalid_d  = gvalid_q;
    txv_d     = txv_q;
    txd_d     = txd_q;
    hlast_d   = hlast_q;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    gap_cnt_d = gap_cnt_q;
    to_cnt_d  = to_cnt_q;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          state_d  = LOCK;
          gid_d    = win_id;
          gvalid_d = 1'b1;
          to_cnt_d = '0;
        end
      end
      LOCK: begin
        if (capture) begin
          txd_d    = sel_data;
          hlast_d  = sel_last;
          txv_d    = 1'b1;
          to_cnt_d = '0;
        end else if (drain) begin
          txv_d = 1'b0;
          if (hlast_q) begin
            done_d    = 1'b1;
            gvalid_d  = 1'b0;
            ptr_d     = ptr_next;
            gap_cnt_d = '0;
            state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end else if (!txv_q && (TIMEOUT_CYCLES != 0)) begin
          // Only an empty holding register counts as a producer stall.
          if (to_cnt_q == TO_LAST) begin
            tmo_d    = 1'b1;
            gvalid_d = 1'b0;
            ptr_d    = ptr_next;
            to_cnt_d = '0;
            state_d  = IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gid_q     <= '0;
      gvalid_q  <= 1'b0;
      txv_q     <= 1'b0;
      txd_q     <= 8'h00;
      hlast_q   <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      gap_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
      gvalid_q  <= gvalid_d;
      txv_q     <= txv_d;
      txd_q     <= txd_d;
      hlast_q   <= hlast_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      gap_cnt_q <= gap_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign bus.req_ready   = ready;
  assign bus.tx_valid    = txv_q;
  assign bus.tx_data     = txd_q;
  assign bus.grant_valid = gvalid_q;
  assign bus.grant_id    = gid_q;
  assign bus.msg_done    = done_q;
  assign bus.timeout_err = tmo_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: instance A (no gap, 16-cycle timeout)
// and instance B (5-cycle gap, timeout disabled) share clock and reset.
module tb_uart_tx_arbiter;
  logic mclk;
  logic rst_n;

  uart_tx_arbiter_if #(.NUM_REQ(4)) a ();
  uart_tx_arbiter_if #(.NUM_REQ(4)) b ();

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(16)) dut_a (
    .mclk(mclk), .rst_n(rst_n), .bus(a)
  );
  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(5), .TIMEOUT_CYCLES(0)) dut_b (
    .mclk(mclk), .rst_n(rst_n), .bus(b)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;

  // Producer queues: bit 8 = last, bits 7:0 = byte.
  logic [8:0] pq_a [4][$];
  logic [8:0] pq_b [4][$];

  logic [7:0] txd_log[$];
  int         txc_log[$];
  int         gid_log[$];
  int         gcyc_log[$];
  int         done_log[$];
  int         to_log[$];
  logic [7:0] btxd_log[$];
  int         bgid_log[$];
  int         bgcyc_log[$];
  int         bdone_log[$];

  logic       prev_gv_a, prev_gv_b;
  logic       s_txv, s_gv, s_to;
  logic [7:0] s_txd;
  logic [3:0] s_rr, sb_rr;
  logic       sb_gv;

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      a.req_valid[i]       = (pq_a[i].size() != 0);
      a.req_data[i*8 +: 8] = (pq_a[i].size() != 0) ? pq_a[i][0][7:0] : 8'h00;
      a.req_last[i]        = (pq_a[i].size() != 0) ? pq_a[i][0][8] : 1'b0;
      b.req_valid[i]       = (pq_b[i].size() != 0);
      b.req_data[i*8 +: 8] = (pq_b[i].size() != 0) ? pq_b[i][0][7:0] : 8'h00;
      b.req_last[i]        = (pq_b[i].size() != 0) ? pq_b[i][0][8] : 1'b0;
    end
  endtask

  task automatic clear_logs();
    txd_log.delete();  txc_log.delete();  gid_log.delete();  gcyc_log.delete();
    done_log.delete(); to_log.delete();
    btxd_log.delete(); bgid_log.delete(); bgcyc_log.delete(); bdone_log.delete();
    s_txv = 1'b0; s_gv = 1'b0; s_to = 1'b0; s_txd = 8'h00; s_rr = '0;
    sb_rr = '0; sb_gv = 1'b0;
  endtask

  // One clock: observe at the falling edge, advance producers after the rising edge.
  task automatic step();
    logic [3:0] fire_a, fire_b;
    @(negedge mclk);
    s_txv = a.tx_valid; s_txd = a.tx_data; s_rr = a.req_ready;
    s_gv  = a.grant_valid; s_to = a.timeout_err;
    sb_rr = b.req_ready; sb_gv = b.grant_valid;
    fire_a = a.req_valid & a.req_ready;
    fire_b = b.req_valid & b.req_ready;
    if (a.tx_valid && a.tx_ready) begin txd_log.push_back(a.tx_data); txc_log.push_back(cyc); end
    if (a.grant_valid && !prev_gv_a) begin gid_log.push_back(int'(a.grant_id)); gcyc_log.push_back(cyc); end
    prev_gv_a = a.grant_valid;
    if (a.msg_done)    done_log.push_back(cyc);
    if (a.timeout_err) to_log.push_back(cyc);
    if (b.tx_valid && b.tx_ready) btxd_log.push_back(b.tx_data);
    if (b.grant_valid && !prev_gv_b) begin bgid_log.push_back(int'(b.grant_id)); bgcyc_log.push_back(cyc); end
    prev_gv_b = b.grant_valid;
    if (b.msg_done) bdone_log.push_back(cyc);
    @(posedge mclk);
    cyc++;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (fire_a[i]) void'(pq_a[i].pop_front());
      if (fire_b[i]) void'(pq_b[i].pop_front());
    end
    drive();
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin pq_a[i].delete(); pq_b[i].delete(); end
    drive();
    repeat (2) @(posedge mclk);
    #1 rst_n = 1'b1;
    prev_gv_a = 1'b0;
    prev_gv_b = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (a.tx_valid !== 1'b0 || a.tx_data !== 8'h00) begin
      $display("FAIL reset_tx: got valid=%b data=%h, expected valid=0 data=00", a.tx_valid, a.tx_data);
    end else pass_cnt++;
    total++;
    if (a.grant_valid !== 1'b0 || a.grant_id !== 2'd0) begin
      $display("FAIL reset_grant: got valid=%b id=%0d, expected 0/0", a.grant_valid, a.grant_id);
    end else pass_cnt++;
    total++;
    if (a.msg_done !== 1'b0 || a.timeout_err !== 1'b0 || a.req_ready !== 4'b0000) begin
      $display("FAIL reset_pulses: got done=%b tmo=%b ready=%b, expected 0 0 0000",
               a.msg_done, a.timeout_err, a.req_ready);
    end else pass_cnt++;
    total++;
    if (b.grant_valid !== 1'b0 || b.tx_valid !== 1'b0) begin
      $display("FAIL reset_b: got grant=%b tx_valid=%b, expected 0 0", b.grant_valid, b.tx_valid);
    end else pass_cnt++;
    @(posedge mclk);
    #1 rst_n = 1'b1;
    clear_logs();
    repeat (3) step();
    total++;
    if (s_gv !== 1'b0 || gid_log.size() != 0) begin
      $display("FAIL idle_no_req: got grant=%b grants=%0d, expected 0 0", s_gv, gid_log.size());
    end else pass_cnt++;
  endtask

  task automatic test_single();
    clear_logs();
    a.tx_ready = 1'b1;
    pq_a[0] = '{9'h048, 9'h069, 9'h10A};
    drive();
    for (int n = 0; n < 30 && done_log.size() == 0; n++) step();
    repeat (3) step();
    total++;
    if (txd_log.size() != 3 || txd_log[0] !== 8'h48 || txd_log[1] !== 8'h69 || txd_log[2] !== 8'h0A) begin
      $display("FAIL single_bytes: got n=%0d %h %h %h, expected n=3 48 69 0a",
               txd_log.size(), txd_log[0], txd_log[1], txd_log[2]);
    end else pass_cnt++;
    total++;
    if (txc_log[1] - txc_log[0] != 2 || txc_log[2] - txc_log[1] != 2) begin
      $display("FAIL single_spacing: got %0d %0d, expected 2 2",
               txc_log[1] - txc_log[0], txc_log[2] - txc_log[1]);
    end else pass_cnt++;
    total++;
    if (done_log.size() != 1 || done_log[0] != txc_log[2] + 1) begin
      $display("FAIL single_done: got n=%0d at %0d, expected n=1 at %0d",
               done_log.size(), done_log[0], txc_log[2] + 1);
    end else pass_cnt++;
    total++;
    if (gid_log.size() != 1 || gid_log[0] != 0 || gcyc_log[0] != txc_log[0] - 1) begin
      $display("FAIL single_grant: got n=%0d id=%0d at %0d, expected n=1 id=0 at %0d",
               gid_log.size(), gid_log[0], gcyc_log[0], txc_log[0] - 1);
    end else pass_cnt++;
  endtask

  task automatic test_round_robin();
    apply_reset();
    a.tx_ready = 1'b1;
    pq_a[1] = '{9'h0A1, 9'h1A2};
    pq_a[2] = '{9'h0B1, 9'h1B2};
    drive();
    for (int n = 0; n < 60 && done_log.size() < 2; n++) step();
    step();
    total++;
    if (txd_log.size() != 4 || txd_log[0] !== 8'hA1 || txd_log[1] !== 8'hA2 ||
        txd_log[2] !== 8'hB1 || txd_log[3] !== 8'hB2) begin
      $display("FAIL rr_bytes: got n=%0d %h %h %h %h, expected n=4 a1 a2 b1 b2",
               txd_log.size(), txd_log[0], txd_log[1], txd_log[2], txd_log[3]);
    end else pass_cnt++;
    total++;
    if (gid_log.size() != 2 || gid_log[0] != 1 || gid_log[1] != 2) begin
      $display("FAIL rr_order: got n=%0d %0d %0d, expected n=2 1 2", gid_log.size(), gid_log[0], gid_log[1]);
    end else pass_cnt++;
    total++;
    if (gcyc_log[1] != done_log[0] + 1) begin
      $display("FAIL rr_regrant: got cycle %0d, expected %0d", gcyc_log[1], done_log[0] + 1);
    end else pass_cnt++;
    clear_logs();
    pq_a[0] = '{9'h1C0};
    pq_a[3] = '{9'h1D3};
    drive();
    for (int n = 0; n < 40 && done_log.size() < 2; n++) step();
    step();
    total++;
    if (gid_log.size() != 2 || gid_log[0] != 3 || gid_log[1] != 0) begin
      $display("FAIL rr_round2: got n=%0d %0d %0d, expected n=2 3 0", gid_log.size(), gid_log[0], gid_log[1]);
    end else pass_cnt++;
    total++;
    if (txd_log.size() != 2 || txd_log[0] !== 8'hD3 || txd_log[1] !== 8'hC0) begin
      $display("FAIL rr_round2_bytes: got n=%0d %h %h, expected n=2 d3 c0",
               txd_log.size(), txd_log[0], txd_log[1]);
    end else pass_cnt++;
  endtask

  task automatic test_back_pressure();
    int bad;
    clear_logs();
    bad = 0;
    a.tx_ready = 1'b0;
    pq_a[0] = '{9'h155};
    drive();
    for (int n = 0; n < 10 && !s_txv; n++) step();
    pq_a[1] = '{9'h166};
    drive();
    for (int n = 0; n < 20; n++) begin
      step();
      if (s_txv !== 1'b1 || s_txd !== 8'h55 || s_rr !== 4'b0000 || s_to !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) begin
      $display("FAIL bp_hold: got %0d disturbed cycles (last valid=%b data=%h ready=%b tmo=%b), expected 0",
               bad, s_txv, s_txd, s_rr, s_to);
    end else pass_cnt++;
    a.tx_ready = 1'b1;
    for (int n = 0; n < 30 && done_log.size() < 2; n++) step();
    total++;
    if (txd_log.size() != 2 || txd_log[0] !== 8'h55 || txd_log[1] !== 8'h66) begin
      $display("FAIL bp_release: got n=%0d %h %h, expected n=2 55 66", txd_log.size(), txd_log[0], txd_log[1]);
    end else pass_cnt++;
    total++;
    if (to_log.size() != 0 || gid_log.size() != 2 || gid_log[1] != 1) begin
      $display("FAIL bp_grants: got timeouts=%0d grants=%0d second=%0d, expected 0 2 1",
               to_log.size(), gid_log.size(), gid_log[1]);
    end else pass_cnt++;
  endtask

  task automatic test_timeout();
    apply_reset();
    a.tx_ready = 1'b1;
    pq_a[3] = '{9'h033};
    drive();
    for (int n = 0; n < 10 && gid_log.size() == 0; n++) step();
    pq_a[0] = '{9'h1C5};
    drive();
    for (int n = 0; n < 40 && to_log.size() == 0; n++) step();
    total++;
    if (s_to !== 1'b1 || s_gv !== 1'b0) begin
      $display("FAIL timeout_pulse: got tmo=%b grant=%b, expected 1 0", s_to, s_gv);
    end else pass_cnt++;
    total++;
    if (txc_log.size() < 1 || to_log[0] != txc_log[0] + 17) begin
      $display("FAIL timeout_delay: got cycle %0d, expected %0d", to_log[0], txc_log[0] + 17);
    end else pass_cnt++;
    for (int n = 0; n < 20 && done_log.size() == 0; n++) step();
    total++;
    if (gid_log.size() != 2 || gid_log[1] != 0 || gcyc_log[1] != to_log[0] + 1) begin
      $display("FAIL timeout_next: got n=%0d id=%0d at %0d, expected n=2 id=0 at %0d",
               gid_log.size(), gid_log[1], gcyc_log[1], to_log[0] + 1);
    end else pass_cnt++;
    total++;
    if (txd_log.size() != 2 || txd_log[1] !== 8'hC5 || to_log.size() != 1) begin
      $display("FAIL timeout_after: got bytes=%0d second=%h timeouts=%0d, expected 2 c5 1",
               txd_log.size(), txd_log[1], to_log.size());
    end else pass_cnt++;
  endtask

  task automatic test_gap();
    int bad;
    apply_reset();
    bad = 0;
    b.tx_ready = 1'b1;
    pq_b[0] = '{9'h011, 9'h112};
    pq_b[1] = '{9'h121};
    drive();
    for (int n = 0; n < 60 && bdone_log.size() < 2; n++) begin
      step();
      if (bdone_log.size() == 1 && bgid_log.size() == 1 && (sb_rr !== 4'b0000 || sb_gv !== 1'b0)) bad++;
    end
    total++;
    if (bgid_log.size() != 2 || bgid_log[0] != 0 || bgid_log[1] != 1) begin
      $display("FAIL gap_order: got n=%0d %0d %0d, expected n=2 0 1", bgid_log.size(), bgid_log[0], bgid_log[1]);
    end else pass_cnt++;
    total++;
    if (bgcyc_log[1] != bdone_log[0] + 6) begin
      $display("FAIL gap_len: got grant at %0d, expected %0d", bgcyc_log[1], bdone_log[0] + 6);
    end else pass_cnt++;
    total++;
    if (bad != 0) begin
      $display("FAIL gap_quiet: got %0d cycles with grant/ready during gap, expected 0", bad);
    end else pass_cnt++;
    total++;
    if (btxd_log.size() != 3 || btxd_log[0] !== 8'h11 || btxd_log[1] !== 8'h12 || btxd_log[2] !== 8'h21) begin
      $display("FAIL gap_bytes: got n=%0d %h %h %h, expected n=3 11 12 21",
               btxd_log.size(), btxd_log[0], btxd_log[1], btxd_log[2]);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    clear_logs();
    a.tx_ready = 1'b1;
    pq_a[0] = '{9'h177};
    drive();
    for (int n = 0; n < 20 && done_log.size() == 0; n++) step();
    pq_a[2] = '{9'h0E1, 9'h0E2, 9'h1E3};
    drive();
    for (int n = 0; n < 20 && txd_log.size() < 2; n++) step();
    a.tx_ready = 1'b0;
    for (int n = 0; n < 10 && !(s_txv && s_txd == 8'hE2); n++) step();
    total++;
    if (a.tx_valid !== 1'b1 || a.tx_data !== 8'hE2) begin
      $display("FAIL mid_pending: got valid=%b data=%h, expected 1 e2", a.tx_valid, a.tx_data);
    end else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (a.tx_valid !== 1'b0 || a.grant_valid !== 1'b0 || a.msg_done !== 1'b0) begin
      $display("FAIL mid_reset: got valid=%b grant=%b done=%b, expected 0 0 0",
               a.tx_valid, a.grant_valid, a.msg_done);
    end else pass_cnt++;
    total++;
    if (a.tx_data !== 8'h00 || a.req_ready !== 4'b0000 || a.grant_id !== 2'd0) begin
      $display("FAIL mid_reset_data: got data=%h ready=%b id=%0d, expected 00 0000 0",
               a.tx_data, a.req_ready, a.grant_id);
    end else pass_cnt++;
    for (int i = 0; i < 4; i++) pq_a[i].delete();
    drive();
    repeat (2) @(posedge mclk);
    #1 rst_n = 1'b1;
    prev_gv_a = 1'b0;
    prev_gv_b = 1'b0;
    clear_logs();
    a.tx_ready = 1'b1;
    pq_a[0] = '{9'h1F0};
    pq_a[2] = '{9'h1F2};
    drive();
    for (int n = 0; n < 30 && done_log.size() < 2; n++) step();
    total++;
    if (gid_log.size() != 2 || gid_log[0] != 0 || gid_log[1] != 2) begin
      $display("FAIL mid_restart: got n=%0d %0d %0d, expected n=2 0 2", gid_log.size(), gid_log[0], gid_log[1]);
    end else pass_cnt++;
    total++;
    if (txd_log.size() != 2 || txd_log[0] !== 8'hF0 || txd_log[1] !== 8'hF2) begin
      $display("FAIL mid_discard: got n=%0d %h %h, expected n=2 f0 f2", txd_log.size(), txd_log[0], txd_log[1]);
    end else pass_cnt++;
  endtask

  initial begin
    rst_n      = 1'b0;
    a.tx_ready = 1'b0;
    b.tx_ready = 1'b0;
    prev_gv_a  = 1'b0;
    prev_gv_b  = 1'b0;
    clear_logs();
    drive();
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_timeout();
    test_gap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter sharing one byte-level UART transmitter between `NUM_REQ` message sources on the `mclk` domain. A requester is granted the transmitter for a whole message, delimited by `req_last`, so bytes from different sources never interleave. Each granted byte passes through a one-byte holding register before it is offered to the serializer. The block sits between the message producers (status/log sources, the greeting generator) and the UART serializer. It also guards against stalled producers with an idle timeout and can insert a fixed inter-message gap.

## Interface
- `NUM_REQ`, 4: number of requesters, 1..8.
- `GAP_CYCLES`, 0: idle `mclk` cycles inserted after each message; 0 means no gap.
- `TIMEOUT_CYCLES`, 1000000: maximum hold-empty cycles while a grant is held; 0 disables the timeout.
- `GW`, derived: `max(1, clog2(NUM_REQ))`.

- `mclk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, NUM_REQ: per-requester byte valid.
- `req_data`, in, NUM_REQ*8: byte for requester i at bits [i*8+7 : i*8].
- `req_last`, in, NUM_REQ: the offered byte ends the message.
- `req_ready`, out, NUM_REQ: per-requester byte accept (combinational).
- `tx_valid`, out, 1: byte available to the serializer (registered).
- `tx_data`, out, 8: byte to the serializer (registered).
- `tx_ready`, in, 1: serializer accepts `tx_data`.
- `grant_valid`, out, 1: a grant is held.
- `grant_id`, out, GW: index of the granted requester.
- `msg_done`, out, 1: one-cycle pulse when the last byte is accepted downstream.
- `timeout_err`, out, 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- States:
  - IDLE: no grant.
  - LOCK: grant held.
  - GAP: post-message gap.
- Reset values: state IDLE, `tx_valid` 0, `tx_data` 0x00, hold-last 0, `grant_valid` 0, `grant_id` 0, `msg_done` 0, `timeout_err` 0, round-robin pointer 0, gap counter 0, timeout counter 0.
- IDLE → LOCK when any `req_valid` bit is set.
  - The winner is the first set bit searching upward from the pointer, wrapping at NUM_REQ-1.
  - Register `grant_id`; set `grant_valid`.
- `req_ready[i]` = (state==LOCK) && !`tx_valid` && (`grant_id`==i). All other bits are 0.
- Capture: on `req_valid[g]` && `req_ready[g]`:
  - hold ← `req_data[g]`, hold-last ← `req_last[g]`.
  - `tx_valid` ← 1.
  - Timeout counter clears.
- Drain: on `tx_valid` && `tx_ready`:
  - `tx_valid` ← 0.
  - If hold-last: pulse `msg_done`; clear `grant_valid`; pointer ← (`grant_id`+1) mod NUM_REQ.
  - Then go to GAP if `GAP_CYCLES`>0, else IDLE.
- `tx_data` must remain stable while `tx_valid`=1 and `tx_ready`=0.
- Timeout:
  - In LOCK with `tx_valid`=0 and no capture this cycle, the counter increments.
  - When it reaches `TIMEOUT_CYCLES`: pulse `timeout_err`, release the grant, advance the pointer, go to IDLE.
  - The counter never runs while `tx_valid`=1 (downstream back-pressure is not a producer stall).
- GAP: count `GAP_CYCLES` cycles, then go to IDLE. No grant and no `req_ready` during GAP.
- Requests from non-granted requesters are held off (`req_ready`=0) and never dropped.
- Deasserting `req_valid` mid-message does not release the grant. Only `req_last` or timeout releases it.

## Timing
- Arbitration latency:
  - `req_valid` sampled high in IDLE at edge k.
  - `grant_valid`/`grant_id` valid after k; `req_ready` high in cycle k+1.
  - Byte captured at edge k+1; `tx_valid` high after k+1.
- Byte throughput: at most one byte per 2 cycles (capture, then drain); `tx_ready` held at 1 gives exactly 2.
- Last byte drained at edge m:
  - `msg_done`=1 in cycle m+1.
  - With `GAP_CYCLES`=0, a new grant is registered at edge m+1.
  - With `GAP_CYCLES`=G, a new grant is registered at edge m+G+1.
- Simultaneous requests in IDLE: round-robin order only; the pointer moves only on release.
- `NUM_REQ`=1: the pointer stays 0 and `grant_id` stays 0.
- Async reset mid-message: all outputs return to reset values immediately and the in-flight byte is discarded. The serializer is reset by the same `rst_n`.

## Test plan
- Single source, req0 sends 0x48, 0x69, 0x0A(last) with `tx_ready`=1 → `tx_data` sequence 48, 69, 0A at 2-cycle spacing, one `msg_done` pulse, `grant_id`=0.
- req1 and req2 both valid from reset, 2-byte messages each → req1 serviced fully, then req2, no interleaving. A second round starts at req3 if valid, else wraps to req0.
- Back-pressure: hold `tx_ready`=0 for 20 cycles with byte 0x55 pending → `tx_valid`=1 and `tx_data`=0x55 stable, `req_ready`=0, no `timeout_err`.
- `TIMEOUT_CYCLES`=16: req3 sends one non-last byte, then drops `req_valid` → `timeout_err` pulse 16 cycles after the drain, `grant_valid`=0, req0 is granted next if pending.
- `GAP_CYCLES`=5: back-to-back messages from req0 and req1 → 5 cycles with `grant_valid`=0 between the `msg_done` pulse and req1's grant.
- Assert `rst_n`=0 while the second byte is pending → `tx_valid`, `grant_valid`, `msg_done` go to 0 immediately. After release, arbitration restarts with the pointer at req0.
